// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES encryption engine (AES-128/192/256, 1 or 2 rounds per clock).
// A plaintext block and its precomputed key schedule are accepted on a valid/ready handshake.
// The rounds run in a registered loop and the ciphertext is offered on a second valid/ready
// handshake.
// All 128-bit vectors are declared [0:127]: bit 0 is the MSB and byte i is bits [8i +: 8].
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   in_valid        plaintext and key schedule valid
//   in_ready        core accepts a block this cycle
//   in_block        plaintext
//   in_key_schedule round keys, round key r at bits [r*128 +: 128]
//   out_valid       ciphertext valid, held until out_ready
//   out_ready       downstream accepts ciphertext
//   out_block       ciphertext
//   busy            rounds in progress
module aes_encrypt_core #(
    parameter int unsigned KEY_BITS         = 128,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    localparam int unsigned NR      = (KEY_BITS == 256) ? 14 : ((KEY_BITS == 192) ? 12 : 10),
    localparam int unsigned KS_BITS = (NR + 1) * 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       in_block,
    input  logic [0:KS_BITS-1] in_key_schedule,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:127]       out_block,
    output logic               busy
);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_encrypt_core: KEY_BITS must be 128, 192 or 256");
    end
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
        $error("aes_encrypt_core: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    // S-box table, entry b at bits [8b +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [0:127] blk_q;
    logic [0:127] out_q;
    logic [3:0]   rnd_q;
    logic [0:KS_BITS-1] ks_q;
    logic [0:127] rk [NR+1];
    logic [0:127] round_out;
    logic         accept;
    logic         last_run;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] key,
                                               input logic last);
        logic [0:127] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            sb[8*i +: 8] = sub_byte(s[8*i +: 8]);
        end
        // Row r of column c takes row r of column c+r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[32*c +: 8];
            a1 = sr[32*c+8 +: 8];
            a2 = sr[32*c+16 +: 8];
            a3 = sr[32*c+24 +: 8];
            mc[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return (last ? sr : mc) ^ key;
    endfunction

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign rk[r] = ks_q[r*128 +: 128];
    end

    assign accept   = in_valid && in_ready;
    assign last_run = (fsm_q == StRun) && ((rnd_q + 4'(ROUNDS_PER_CYCLE - 1)) == 4'(NR));

    // Chain of ROUNDS_PER_CYCLE rounds, numbered rnd_q upwards.
    always_comb begin
        round_out = blk_q;
        for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            round_out = aes_round(round_out, rk[rnd_q + 4'(k)], (rnd_q + 4'(k)) == 4'(NR));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle: if (accept) fsm_d = StRun;
            StRun:  if (last_run) fsm_d = StDone;
            // A same-cycle output handshake and input accept skips Idle.
            StDone: if (out_ready) fsm_d = accept ? StRun : StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && ((fsm_q == StIdle) || ((fsm_q == StDone) && out_ready));
        out_valid = rst_n && (fsm_q == StDone);
        busy      = (fsm_q == StRun);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_q <= '0;
            out_q <= '0;
            rnd_q <= '0;
            ks_q  <= '0;
        end else if (accept) begin
            ks_q  <= in_key_schedule;
            blk_q <= in_block ^ in_key_schedule[0:127];
            rnd_q <= 4'd1;
        end else if (fsm_q == StRun) begin
            blk_q <= round_out;
            // Park the counter at 0 so it never indexes past the last round key.
            rnd_q <= last_run ? 4'd0 : rnd_q + 4'(ROUNDS_PER_CYCLE);
            if (last_run) begin
                out_q <= round_out;
            end
        end
    end

    assign out_block = out_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: four instances (AES-128 x1, AES-128 x2, AES-192, AES-256)
// driven with FIPS-197 vectors. The bench expands keys itself; ciphertexts are FIPS constants.
module tb_aes_encrypt_core;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [0:127] blk;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         iv   [4];
    logic         ir   [4];
    logic [0:127] ib   [4];
    logic         ov   [4];
    logic         ordy [4];
    logic [0:127] ob   [4];
    logic         bz   [4];
    logic [0:1407] ks0, ks1;
    logic [0:1663] ks2;
    logic [0:1919] ks3;

    logic [0:1919] ks_b, ks_c, ks_192, ks_256;

    exp_t sbq [4][$];
    exp_t cur [4];
    bit   have [4];
    bit   ov_prev [4];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    aes_encrypt_core #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_block(ib[0]),
        .in_key_schedule(ks0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_block(ob[0]),
        .busy(bz[0]));
    aes_encrypt_core #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_block(ib[1]),
        .in_key_schedule(ks1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_block(ob[1]),
        .busy(bz[1]));
    aes_encrypt_core #(.KEY_BITS(192), .ROUNDS_PER_CYCLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_block(ib[2]),
        .in_key_schedule(ks2), .out_valid(ov[2]), .out_ready(ordy[2]), .out_block(ob[2]),
        .busy(bz[2]));
    aes_encrypt_core #(.KEY_BITS(256), .ROUNDS_PER_CYCLE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_block(ib[3]),
        .in_key_schedule(ks3), .out_valid(ov[3]), .out_ready(ordy[3]), .out_block(ob[3]),
        .busy(bz[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 10;
            1:       return 5;
            2:       return 12;
            default: return 14;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[{w[8*i +: 8], 3'b000} +: 8];
        return r;
    endfunction

    // FIPS-197 key expansion; nk = key length in 32-bit words.
    function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1919] ks;
        int            nw;
        nw   = 4 * (nk + 7);
        rcon = 8'h01;
        ks   = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                w[i] = key[32*i +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            ks[32*i +: 32] = w[i];
        end
        return ks;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [0:127] pt,
                         input logic [0:1919] ks);
        iv[d] = v;
        ib[d] = pt;
        case (d)
            0:       ks0 = ks[0:1407];
            1:       ks1 = ks[0:1407];
            2:       ks2 = ks[0:1663];
            default: ks3 = ks;
        endcase
    endtask

    // Called just after a falling edge; returns just after a later falling edge.
    task automatic send(input int d, input logic [0:127] pt, input logic [0:1919] ks,
                        input logic [0:127] ct, input bit corrupt, output int waited);
        logic [0:1919] g;
        exp_t          e;
        drive(d, 1'b1, pt, ks);
        #1;
        waited = 0;
        while (!ir[d] && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check($sformatf("dut%0d_accept_ready", d), 128'(ir[d]), 128'd1);
        if (!ir[d]) begin
            drive(d, 1'b0, '0, '0);
            return;
        end
        e.blk = ct;
        e.acc = cyc;
        sbq[d].push_back(e);
        @(posedge clk);
        #1;
        check($sformatf("dut%0d_busy_after_accept", d), 128'(bz[d]), 128'd1);
        if (corrupt) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                for (int i = 0; i < 60; i++) g[32*i +: 32] = $urandom;
                drive(d, 1'b1, {$urandom, $urandom, $urandom, $urandom}, g);
            end
            @(negedge clk);
        end
        drive(d, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            pend = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
            for (int d = 0; d < 4; d++) if (ov[d]) pend++;
        end
        check("drain_pending", 128'(pend), 128'd0);
    endtask

    // Monitor: pops an expectation when out_valid rises, then checks out_block while it is held.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
                have[d] = 1'b0;
            end else if (ov[d]) begin
                if (!ov_prev[d]) begin
                    if (sbq[d].size() == 0) begin
                        check($sformatf("dut%0d_unexpected_out", d), 128'(ov[d]), 128'd0);
                        have[d] = 1'b0;
                    end else begin
                        cur[d]  = sbq[d].pop_front();
                        have[d] = 1'b1;
                        check($sformatf("dut%0d_latency", d), 128'(cyc - cur[d].acc - 1),
                              128'(lat_of(d)));
                    end
                end
                if (have[d]) check($sformatf("dut%0d_ciphertext", d), ob[d], cur[d].blk);
            end
            ov_prev[d] = ov[d];
        end
    end

    initial begin
        int w;
        ks_b   = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        ks_c   = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        ks_192 = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        ks_256 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                            8);
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            drive(d, 1'b0, '0, '0);
            ordy[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("dut%0d_rst_in_ready", d), 128'(ir[d]), 128'd0);
            check($sformatf("dut%0d_rst_out_valid", d), 128'(ov[d]), 128'd0);
            check($sformatf("dut%0d_rst_out_block", d), ob[d], 128'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("dut%0d_idle_in_ready", d), 128'(ir[d]), 128'd1);
            check($sformatf("dut%0d_idle_busy", d), 128'(bz[d]), 128'd0);
        end

        // Known-answer vectors on every configuration.
        send(0, PT_B, ks_b, CT_B, 1'b0, w);
        send(1, PT_C, ks_c, CT_C1, 1'b0, w);
        send(2, PT_C, ks_192, CT_C2, 1'b0, w);
        send(3, PT_C, ks_256, CT_C3, 1'b0, w);
        drain();

        // Backpressure, then release together with a new block.
        ordy[0] = 1'b0;
        send(0, PT_B, ks_b, CT_B, 1'b0, w);
        w = 0;
        while (!ov[0] && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("bp_out_valid_seen", 128'(ov[0]), 128'd1);
        repeat (20) begin
            @(negedge clk);
            #1;
            check("bp_in_ready_low", 128'(ir[0]), 128'd0);
            check("bp_out_valid_held", 128'(ov[0]), 128'd1);
        end
        ordy[0] = 1'b1;
        send(0, PT_C, ks_c, CT_C1, 1'b0, w);
        check("b2b_accept_wait", 128'(w), 128'd0);
        drain();

        // Inputs churn during the run; the latched block and keys must win.
        send(0, PT_B, ks_b, CT_B, 1'b1, w);
        drain();

        // Reset around round 4 drops the block.
        send(0, PT_B, ks_b, CT_B, 1'b0, w);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sbq[0].delete();
        @(posedge clk);
        #1;
        check("midrst_out_block", ob[0], 128'd0);
        check("midrst_out_valid", 128'(ov[0]), 128'd0);
        check("midrst_in_ready", 128'(ir[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 128'(ir[0]), 128'd1);
        check("postrst_busy", 128'(bz[0]), 128'd0);
        repeat (20) @(negedge clk);
        send(0, PT_C, ks_c, CT_C1, 1'b0, w);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
- Iterative, parametrised AES encryption engine. Successor to the two-rounds-per-call combinational stage function.
- Supports AES-128/192/256 and 1 or 2 rounds per clock.
- Wraps the round datapath in a registered state machine with valid/ready handshakes on input and output.
- Takes a precomputed key schedule from the key-expansion block and emits one ciphertext block per accepted plaintext block.

Parameters:
- KEY_BITS, 128, AES key size; legal values 128/192/256. Gives NR = 10/12/14 rounds. Any other value is an elaboration error.
- ROUNDS_PER_CYCLE, 1, rounds computed per clock; legal values 1/2. NR is always divisible by 2.
- KS_BITS, (NR+1)*128, derived key-schedule width: 1408/1664/1920. Not overridable.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  plaintext and key schedule are valid
- in_ready  out  1  core can accept a block this cycle
- in_block  in  128  plaintext; bit 0 = MSB
- in_key_schedule  in  KS_BITS  round keys; round key r = bits [r*128 +: 128]; bit 0 = MSB
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- out_block  out  128  ciphertext; bit 0 = MSB
- busy  out  1  high in RUN state

Behaviour:
- Byte/bit layout
  - Byte i of the state = bits [8i +: 8]; byte 0 = bits [0:7].
  - Column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
- Round definition
  - SubBytes: FIPS-197 S-box.
  - ShiftRows: row r rotates left by r columns.
  - MixColumns: matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8).
    - xtime reduction: (b<<1) ^ 8'h1B when b[MSB]=1; result truncated to 8 bits.
  - AddRoundKey with round key r.
  - Round NR omits MixColumns.
- Reset (rst_n=0 at a rising edge)
  - FSM -> IDLE; round counter -> 0; state register, key register and out_block -> 0.
  - in_ready=0 and out_valid=0 while rst_n is low.
  - Reset mid-RUN or mid-DONE drops the block with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: latch in_key_schedule into the key register; state <= in_block ^ rk0; round counter <= 1; go to RUN.
- RUN
  - in_ready=0; busy=1.
  - Each cycle applies ROUNDS_PER_CYCLE rounds, numbered counter..counter+RPC-1, using the latched keys; counter += RPC.
  - When the last round applied equals NR: load out_block, go to DONE.
  - in_valid is ignored during RUN.
- DONE
  - out_valid=1; out_block stable until handshake.
  - On out_ready: out_valid falls next cycle; go to IDLE.
- Back-to-back: in_ready = IDLE || (DONE && out_ready).
  - A simultaneous output handshake and input accept goes straight DONE -> RUN, with no IDLE bubble.
- Latency: out_valid rises exactly NR/RPC clocks after the input handshake edge.
  - 10/12/14 clocks at RPC=1; 5/6/7 at RPC=2.
  - Throughput with out_ready tied high: one block per NR/RPC+1 clocks.
- Key schedule is sampled only at the input handshake. Later changes on in_key_schedule have no effect on the in-flight block.
- Holding: out_valid, once high, stays high until out_ready is seen, regardless of in_valid.
- Counter width: 4 bits, with no wrap inside a legal run.

Test Plan:
- KEY_BITS=128, RPC=1: in_block=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c expanded -> out_block=3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 clocks after accept.
- KEY_BITS=128, RPC=2: in_block=00112233445566778899aabbccddeeff, key 000102..0f -> 69c4e0d86a7b0430d8cdb78070b4c55a after 5 clocks.
- KEY_BITS=192 and KEY_BITS=256, RPC=1: plaintext 00112233..eeff.
  - Key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 clocks.
  - Key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 clocks.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_block stable and in_ready=0 throughout. Release out_ready together with a new in_valid -> accept in the same cycle, busy next cycle, no IDLE cycle.
- Key/input corruption: change in_key_schedule and in_block every cycle during RUN -> ciphertext still matches the first vector.
- Reset mid-operation: drive rst_n=0 for one edge at round 4 -> out_valid never rises for that block, out_block=0, in_ready=1 the cycle after rst_n returns high. A following vector completes correctly.
